// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, sample/twiddle types and S3 narrowing helper.
// Narrowing saturates when TWIDDLE_SAT_EN is defined, else wraps.
package fft_pkg;
  localparam int IN_WIDTH    = 10;
  localparam int OUT_WIDTH   = 10;
  localparam int TW_WIDTH    = 9;
  localparam int TW_FLT      = 7;
  localparam int DEF_NUM     = 16;
  localparam int DEF_DATA    = 512;
  localparam int PROD_W      = IN_WIDTH + TW_WIDTH;
  localparam int SUM_W       = PROD_W + 1;
  localparam int ROUND_CONST = 1 << (TW_FLT - 1);

  typedef logic signed [TW_WIDTH-1:0]  tw_t;
  typedef logic signed [PROD_W-1:0]    prod_t;
  typedef logic signed [SUM_W-1:0]     sum_t;
  typedef logic signed [OUT_WIDTH-1:0] out_t;

  typedef struct packed {
    logic signed [IN_WIDTH-1:0] re;
    logic signed [IN_WIDTH-1:0] im;
  } cplx_in_t;

  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] re;
    logic signed [OUT_WIDTH-1:0] im;
  } cplx_out_t;

`ifdef TWIDDLE_SAT_EN
  localparam sum_t SAT_HI = sum_t'((1 << (OUT_WIDTH - 1)) - 1);
  localparam sum_t SAT_LO = sum_t'(-(1 << (OUT_WIDTH - 1)));
`endif

  // Elaboration-time table entry: round(2^TW_FLT * cos/sin(2*pi*idx/data))
  function automatic tw_t tw_val(input int idx, input int data,
                                 input bit sine);
    real ang;
    real v;
    int  r;
    ang = 6.283185307179586 * real'(idx) / real'(data);
    v   = (sine ? $sin(ang) : $cos(ang)) * real'(1 << TW_FLT);
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return TW_WIDTH'(r);
  endfunction

  function automatic out_t narrow(input sum_t x);
`ifdef TWIDDLE_SAT_EN
    if (x > SAT_HI) return out_t'(SAT_HI);
    if (x < SAT_LO) return out_t'(SAT_LO);
    return out_t'(x);
`else
    return out_t'(x);
`endif
  endfunction
endpackage

// File: rtl/twiddle_mul_if.sv
// twiddle_mul_if: butterfly-side beat inputs and twiddle-stage outputs.
// master drives din*/valid_in; slave is the twiddle stage.
interface twiddle_mul_if #(
  parameter int NUM = fft_pkg::DEF_NUM
);
  import fft_pkg::*;

  logic signed [IN_WIDTH-1:0]  din1_re  [NUM];
  logic signed [IN_WIDTH-1:0]  din1_im  [NUM];
  logic signed [IN_WIDTH-1:0]  din2_re  [NUM];
  logic signed [IN_WIDTH-1:0]  din2_im  [NUM];
  logic                        valid_in;
  logic signed [OUT_WIDTH-1:0] dout1_re [NUM];
  logic signed [OUT_WIDTH-1:0] dout1_im [NUM];
  logic signed [OUT_WIDTH-1:0] dout2_re [NUM];
  logic signed [OUT_WIDTH-1:0] dout2_im [NUM];
  logic                        valid_out;

  modport master (
    output din1_re, din1_im, din2_re, din2_im, valid_in,
    input  dout1_re, dout1_im, dout2_re, dout2_im, valid_out
  );

  modport slave (
    input  din1_re, din1_im, din2_re, din2_im, valid_in,
    output dout1_re, dout1_im, dout2_re, dout2_im, valid_out
  );
endinterface

// File: rtl/twiddle_rom.sv
// twiddle_rom: constant cos/sin table for idx 0..DATA/2-1,
// NUM independent read ports with registered outputs.
module twiddle_rom #(
  parameter int DATA     = fft_pkg::DEF_DATA,
  parameter int NUM      = fft_pkg::DEF_NUM,
  parameter int TW_WIDTH = fft_pkg::TW_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [$clog2(DATA/2)-1:0]  addr_i [NUM],
  output logic signed [TW_WIDTH-1:0] cos_o  [NUM],
  output logic signed [TW_WIDTH-1:0] sin_o  [NUM]
);
  localparam int HALF = DATA / 2;

  logic signed [TW_WIDTH-1:0] cos_tab [HALF];
  logic signed [TW_WIDTH-1:0] sin_tab [HALF];

  for (genvar i = 0; i < HALF; i++) begin : g_tab
    assign cos_tab[i] = TW_WIDTH'(fft_pkg::tw_val(i, DATA, 1'b0));
    assign sin_tab[i] = TW_WIDTH'(fft_pkg::tw_val(i, DATA, 1'b1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NUM; p++) begin
        cos_o[p] <= '0;
        sin_o[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM; p++) begin
        cos_o[p] <= cos_tab[addr_i[p]];
        sin_o[p] <= sin_tab[addr_i[p]];
      end
    end
  end
endmodule

// File: rtl/twiddle_mul.sv
// twiddle_mul: radix-2 back end; din1 delay-matched, din2 rotated by W^idx.
// Fixed 3-cycle pipe; define TWIDDLE_SAT_EN to saturate instead of wrap.
module twiddle_mul
  import fft_pkg::*;
#(
  parameter int NUM  = DEF_NUM,
  parameter int DATA = DEF_DATA
) (
  input logic          clk,
  input logic          rstn,
  twiddle_mul_if.slave bus
);
  localparam int AW = $clog2(DATA / 2);
  localparam int NW = $clog2(NUM);
  localparam int KW = AW - NW;

  logic [KW-1:0] k_q, k_d;
  logic [2:0]    v_q, v_d;
  logic [AW-1:0] rom_addr [NUM];
  tw_t           cos_w    [NUM];
  tw_t           sin_w    [NUM];

  always_comb begin
    k_d = k_q;
    if (bus.valid_in) k_d = k_q + KW'(1);
    v_d = {v_q[1:0], bus.valid_in};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q <= '0;
      v_q <= '0;
    end else begin
      k_q <= k_d;
      v_q <= v_d;
    end
  end

  assign bus.valid_out = v_q[2];

  twiddle_rom #(
    .DATA     (DATA),
    .NUM      (NUM),
    .TW_WIDTH (TW_WIDTH)
  ) u_rom (
    .clk    (clk),
    .rstn   (rstn),
    .addr_i (rom_addr),
    .cos_o  (cos_w),
    .sin_o  (sin_w)
  );

  for (genvar n = 0; n < NUM; n++) begin : g_lane
    cplx_in_t  d1_s1_q, d1_s2_q, d2_s1_q;
    prod_t     ac_q, bs_q, bc_q, as_q;
    cplx_out_t o1_q, o2_q;
    sum_t      re_s, im_s;

    // ROM reads with the pre-increment beat count, so it lands with S1
    assign rom_addr[n] = {k_q, NW'(n)};

    assign re_s = (sum_t'(ac_q) + sum_t'(bs_q)
                 + sum_t'(ROUND_CONST)) >>> TW_FLT;
    assign im_s = (sum_t'(bc_q) - sum_t'(as_q)
                 + sum_t'(ROUND_CONST)) >>> TW_FLT;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        d1_s1_q <= '0;
        d2_s1_q <= '0;
        d1_s2_q <= '0;
        ac_q    <= '0;
        bs_q    <= '0;
        bc_q    <= '0;
        as_q    <= '0;
        o1_q    <= '0;
        o2_q    <= '0;
      end else begin
        d1_s1_q <= {bus.din1_re[n], bus.din1_im[n]};
        d2_s1_q <= {bus.din2_re[n], bus.din2_im[n]};
        d1_s2_q <= d1_s1_q;
        ac_q    <= prod_t'(d2_s1_q.re) * prod_t'(cos_w[n]);
        bs_q    <= prod_t'(d2_s1_q.im) * prod_t'(sin_w[n]);
        bc_q    <= prod_t'(d2_s1_q.im) * prod_t'(cos_w[n]);
        as_q    <= prod_t'(d2_s1_q.re) * prod_t'(sin_w[n]);
        o1_q    <= {narrow(sum_t'(d1_s2_q.re)),
                    narrow(sum_t'(d1_s2_q.im))};
        o2_q    <= {narrow(re_s), narrow(im_s)};
      end
    end

    assign bus.dout1_re[n] = o1_q.re;
    assign bus.dout1_im[n] = o1_q.im;
    assign bus.dout2_re[n] = o2_q.re;
    assign bus.dout2_im[n] = o2_q.im;
  end
endmodule

// File: tb/tb_twiddle_mul.sv
// tb_twiddle_mul: random beats against a real-math model of the twiddle stage,
// plus hand-computed points (idx 0, 128, 64, wrap, reset flush).
module tb_twiddle_mul;
  localparam int NL = 16;
  localparam int ND = 512;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  twiddle_mul_if #(.NUM(NL)) bus ();

  twiddle_mul #(.NUM(NL), .DATA(ND)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int       checks = 0;
  int       passed = 0;
  int       exp_q [$];
  bit [2:0] hist = '0;
  int       mk = 0;

`ifdef TWIDDLE_SAT_EN
  localparam int T4_RE = -512;
`else
  localparam int T4_RE = 296;
`endif

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s", msg);
  endtask

  function automatic int tw(input int idx, input bit sine);
    real a;
    real x;
    a = 2.0 * 3.141592653589793 * real'(idx) / real'(ND);
    x = 128.0 * (sine ? $sin(a) : $cos(a));
    return $rtoi($floor(x + 0.5));
  endfunction

  function automatic int fit(input int x);
`ifdef TWIDDLE_SAT_EN
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
`else
    int w;
    w = ((x % 1024) + 1024) % 1024;
    return (w >= 512) ? w - 1024 : w;
`endif
  endfunction

  function automatic int rnd(input int x);
    return $rtoi($floor((real'(x) + 64.0) / 128.0));
  endfunction

  task automatic model(input int a, input int b, input int idx,
                       output int re, output int im);
    int c;
    int s;
    c  = tw(idx, 1'b0);
    s  = tw(idx, 1'b1);
    re = fit(rnd(a * c + b * s));
    im = fit(rnd(b * c - a * s));
  endtask

  function automatic bit all_zero();
    bit z;
    z = (bus.valid_out == 1'b0);
    for (int n = 0; n < NL; n++)
      if (bus.dout1_re[n] != 0 || bus.dout1_im[n] != 0 ||
          bus.dout2_re[n] != 0 || bus.dout2_im[n] != 0) z = 1'b0;
    return z;
  endfunction

  always @(negedge rstn) begin
    exp_q.delete();
    hist = '0;
    mk   = 0;
  end

  always @(posedge clk) begin
    int r, i, e1r, e1i, e2r, e2i;
    if (rstn) begin
      hist = {hist[1:0], bus.valid_in};
      if (bus.valid_in) begin
        for (int n = 0; n < NL; n++) begin
          model(int'(bus.din2_re[n]), int'(bus.din2_im[n]),
                mk * NL + n, r, i);
          exp_q.push_back(fit(int'(bus.din1_re[n])));
          exp_q.push_back(fit(int'(bus.din1_im[n])));
          exp_q.push_back(r);
          exp_q.push_back(i);
        end
        mk = (mk + 1) % (ND / (2 * NL));
      end
    end
    #1;
    if (!rstn) begin
      chk(all_zero(), $sformatf("in-reset got vout=%0b want all zero",
                                bus.valid_out));
    end else begin
      chk(bus.valid_out == hist[2],
          $sformatf("valid_out got %0b want %0b", bus.valid_out, hist[2]));
      if (hist[2]) begin
        if (exp_q.size() < 4 * NL) begin
          chk(1'b0, $sformatf("model queue got %0d want %0d",
                              exp_q.size(), 4 * NL));
        end else begin
          for (int n = 0; n < NL; n++) begin
            e1r = exp_q.pop_front();
            e1i = exp_q.pop_front();
            e2r = exp_q.pop_front();
            e2i = exp_q.pop_front();
            chk(int'(bus.dout1_re[n]) == e1r && int'(bus.dout1_im[n]) == e1i &&
                int'(bus.dout2_re[n]) == e2r && int'(bus.dout2_im[n]) == e2i,
                $sformatf("lane%0d got d1=(%0d,%0d) d2=(%0d,%0d) want d1=(%0d,%0d) d2=(%0d,%0d)",
                          n, bus.dout1_re[n], bus.dout1_im[n],
                          bus.dout2_re[n], bus.dout2_im[n],
                          e1r, e1i, e2r, e2i));
          end
        end
      end
    end
  end

  task automatic zero_in();
    for (int n = 0; n < NL; n++) begin
      bus.din1_re[n] = '0;
      bus.din1_im[n] = '0;
      bus.din2_re[n] = '0;
      bus.din2_im[n] = '0;
    end
  endtask

  task automatic drive(input bit v);
    @(negedge clk);
    bus.valid_in = v;
    for (int n = 0; n < NL; n++) begin
      bus.din1_re[n] = 10'($urandom);
      bus.din1_im[n] = 10'($urandom);
      bus.din2_re[n] = 10'($urandom);
      bus.din2_im[n] = 10'($urandom);
    end
  endtask

  task automatic pin(input int d1r, input int d1i, input int d2r,
                     input int d2i, input int e2r, input int e2i,
                     input string nm);
    drive(1'b1);
    bus.din1_re[0] = 10'(d1r);
    bus.din1_im[0] = 10'(d1i);
    bus.din2_re[0] = 10'(d2r);
    bus.din2_im[0] = 10'(d2i);
    drive(1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk(bus.valid_out == 1'b1 &&
        int'(bus.dout1_re[0]) == d1r && int'(bus.dout1_im[0]) == d1i &&
        int'(bus.dout2_re[0]) == e2r && int'(bus.dout2_im[0]) == e2i,
        $sformatf("%s got v=%0b d1=(%0d,%0d) d2=(%0d,%0d) want v=1 d1=(%0d,%0d) d2=(%0d,%0d)",
                  nm, bus.valid_out, bus.dout1_re[0], bus.dout1_im[0],
                  bus.dout2_re[0], bus.dout2_im[0], d1r, d1i, e2r, e2i));
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    chk(all_zero(), $sformatf("%s got vout=%0b want all zero",
                              nm, bus.valid_out));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int r, i;
    zero_in();
    bus.valid_in = 1'b0;

    chk(tw(0, 1'b0) == 128 && tw(0, 1'b1) == 0,
        $sformatf("model tw0 got (%0d,%0d) want (128,0)",
                  tw(0, 1'b0), tw(0, 1'b1)));
    chk(tw(128, 1'b0) == 0 && tw(128, 1'b1) == 128,
        $sformatf("model tw128 got (%0d,%0d) want (0,128)",
                  tw(128, 1'b0), tw(128, 1'b1)));
    chk(tw(64, 1'b0) == 91 && tw(64, 1'b1) == 91,
        $sformatf("model tw64 got (%0d,%0d) want (91,91)",
                  tw(64, 1'b0), tw(64, 1'b1)));
    model(100, -50, 0, r, i);
    chk(r == 100 && i == -50,
        $sformatf("model idx0 got (%0d,%0d) want (100,-50)", r, i));
    model(30, 40, 128, r, i);
    chk(r == 40 && i == -30,
        $sformatf("model idx128 got (%0d,%0d) want (40,-30)", r, i));
    model(-512, -512, 64, r, i);
    chk(r == T4_RE && i == 0,
        $sformatf("model idx64 got (%0d,%0d) want (%0d,0)", r, i, T4_RE));

    repeat (4) drive($urandom_range(0, 1) == 1);
    @(negedge clk);
    rstn = 1'b1;
    zero_in();
    bus.valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk(all_zero(), $sformatf("T1 idle after release got vout=%0b want all zero",
                              bus.valid_out));

    pin(7, -3, 100, -50, 100, -50, "T2 idx0");
    repeat (7) drive(1'b1);
    pin(5, 6, 30, 40, 40, -30, "T3 idx128");
    repeat (11) drive(1'b1);
    pin(-1, 1, -512, -512, T4_RE, 0, "T4 idx64");

    do_reset("T5 reset");
    for (int b = 0; b < 16; b++) begin
      drive(1'b1);
      if (b == 3 || b == 10) drive(1'b0);
    end
    pin(-8, 9, 30, 40, 30, 40, "T5 wrap k0");

    repeat (400) drive($urandom_range(0, 3) != 0);

    do_reset("T6 pre reset");
    repeat (6) drive(1'b1);
    do_reset("T6 mid-frame reset");
    pin(11, -12, 30, 40, 30, 40, "T6 k0 after reset");

    repeat (4) drive(1'b0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
